// File: rtl/osd_cmd_tx.sv
// osd_cmd_tx: paces high-level OSD requests onto the 16-bit osd_command bus.
// Every word is held for HOLD_CYCLES clocks. A 16'h0000 spacer is inserted
// whenever the next word would equal the value already on the bus, because
// the overlay only reacts to a change of bus value.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | ready for a request; osd_command keeps the last emitted word
//   HOLD  | a word or spacer is on the bus; hold_cnt counts its cycles
//   LOAD  | not a register state: folded into the IDLE/HOLD exit so that the
//         | next word (or spacer) appears on the very next cycle
module osd_cmd_tx #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_x,
  input  logic [4:0]  req_y,
  input  logic [7:0]  req_char,
  input  logic [7:0]  req_attr,
  input  logic [7:0]  req_data,
  output logic [15:0] osd_command,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;

  localparam logic [2:0] OP_SET_OVERLAY = 3'd0;
  localparam logic [2:0] OP_SET_POPUP   = 3'd1;
  localparam logic [2:0] OP_PUT_CHAR    = 3'd2;
  localparam logic [2:0] OP_FONT_RESET  = 3'd3;
  localparam logic [2:0] OP_FONT_BYTE   = 3'd4;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic [1:0]  state;
  logic [1:0]  idx_q;
  logic [7:0]  hold_cnt;
  logic        spacer;

  logic [2:0]  op_q;
  logic [4:0]  x_q;
  logic [4:0]  y_q;
  logic [7:0]  char_q;
  logic [7:0]  attr_q;
  logic [7:0]  data_q;

  logic        load_en;
  logic [15:0] load_word;
  logic [1:0]  nxt_idx;
  logic [1:0]  last_idx;
  logic        hold_done;

  // Word idx of the sequence for a given op; upper byte is never zero for a real word.
  function automatic logic [15:0] op_word(
    input logic [2:0] op,
    input logic [1:0] idx,
    input logic [4:0] x,
    input logic [4:0] y,
    input logic [7:0] ch,
    input logic [7:0] at,
    input logic [7:0] d
  );
    logic [15:0] w;
    w = 16'h0000;
    case (op)
      OP_SET_OVERLAY: w = {8'd1, 7'b0, d[0]};
      OP_SET_POPUP:   w = {8'd2, 7'b0, d[0]};
      OP_PUT_CHAR: begin
        case (idx)
          2'd0:    w = {8'd16, 3'b0, x};
          2'd1:    w = {8'd17, 3'b0, y};
          2'd2:    w = {8'd18, ch};
          default: w = {8'd19, at};
        endcase
      end
      OP_FONT_RESET:  w = 16'h2001;
      OP_FONT_BYTE:   w = {8'd33, d};
      default:        w = 16'h0000;
    endcase
    return w;
  endfunction

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
  assign last_idx  = (op_q == OP_PUT_CHAR) ? 2'd3 : 2'd0;
  assign hold_done = (hold_cnt == HOLD_LAST);

  // Decide whether a word is loaded this cycle and which one (merged LOAD step).
  always_comb begin
    load_en   = 1'b0;
    load_word = 16'h0000;
    nxt_idx   = idx_q;
    case (state)
      IDLE: begin
        if (req_valid && (req_op <= OP_FONT_BYTE)) begin
          load_en   = 1'b1;
          nxt_idx   = 2'd0;
          load_word = op_word(req_op, 2'd0, req_x, req_y, req_char, req_attr, req_data);
        end
      end
      default: begin
        if (hold_done) begin
          if (spacer) begin
            load_en   = 1'b1;
            load_word = op_word(op_q, idx_q, x_q, y_q, char_q, attr_q, data_q);
          end else if (idx_q != last_idx) begin
            load_en   = 1'b1;
            nxt_idx   = idx_q + 2'd1;
            load_word = op_word(op_q, idx_q + 2'd1, x_q, y_q, char_q, attr_q, data_q);
          end
        end
      end
    endcase
  end

  // Sequencer: drive word or spacer, count the hold time, return to IDLE when done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx_q       <= 2'd0;
      hold_cnt    <= 8'd0;
      spacer      <= 1'b0;
      osd_command <= 16'h0000;
    end else if (load_en) begin
      state    <= HOLD;
      idx_q    <= nxt_idx;
      hold_cnt <= 8'd0;
      if (load_word == osd_command) begin
        osd_command <= 16'h0000;
        spacer      <= 1'b1;
      end else begin
        osd_command <= load_word;
        spacer      <= 1'b0;
      end
    end else if (state == HOLD) begin
      if (hold_done) begin
        state <= IDLE;
      end else begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

  // Snapshot the request fields at acceptance so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= 3'd0;
      x_q    <= 5'd0;
      y_q    <= 5'd0;
      char_q <= 8'd0;
      attr_q <= 8'd0;
      data_q <= 8'd0;
    end else if (req_ready && req_valid) begin
      op_q   <= req_op;
      x_q    <= req_x;
      y_q    <= req_y;
      char_q <= req_char;
      attr_q <= req_attr;
      data_q <= req_data;
    end
  end

endmodule

// File: tb/tb_osd_cmd_tx.sv
// Testbench for osd_cmd_tx: stimulus pushes expected (word, first-cycle) pairs
// into a scoreboard; a monitor pops and compares on every bus change.
module tb_osd_cmd_tx;

  localparam int H = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_x;
  logic [4:0]  req_y;
  logic [7:0]  req_char;
  logic [7:0]  req_attr;
  logic [7:0]  req_data;
  logic [15:0] osd_command;
  logic        busy;

  osd_cmd_tx #(.HOLD_CYCLES(H)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_char    (req_char),
    .req_attr    (req_attr),
    .req_data    (req_data),
    .osd_command (osd_command),
    .busy        (busy)
  );

  typedef struct {
    logic [15:0] w;
    int          t;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] pend[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          mon_en = 1'b0;
  logic [15:0] prev_cmd = 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the number of the most recent posedge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every change of osd_command must be the next scoreboard entry, on time.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && (osd_command !== prev_cmd)) begin
      if (sb.size() == 0) begin
        check("unexpected_word", {16'h0, osd_command}, {16'h0, prev_cmd});
      end else begin
        e = sb.pop_front();
        check("word_value", {16'h0, osd_command}, {16'h0, e.w});
        check("word_time", cyc, e.t);
      end
      prev_cmd = osd_command;
    end
  end

  task automatic expect_w(input logic [15:0] w);
    pend.push_back(w);
  endtask

  // Issue one request from a negedge. hold=1 keeps req_valid high and scrambles
  // the fields while busy; wait_done=0 returns right after acceptance.
  task automatic issue(input logic [2:0] op, input logic [4:0] x, input logic [4:0] y,
                       input logic [7:0] ch, input logic [7:0] at, input logic [7:0] d,
                       input bit hold, input bit wait_done);
    int t;
    int n;
    int k;
    exp_t e;
    for (k = 0; k < 200 && !req_ready; k++) @(negedge clk);
    if (!req_ready) check("ready_before_issue", {31'h0, req_ready}, 32'd1);
    req_op    = op;
    req_x     = x;
    req_y     = y;
    req_char  = ch;
    req_attr  = at;
    req_data  = d;
    req_valid = 1'b1;
    t = cyc + 1;
    n = pend.size();
    for (int i = 0; i < n; i++) begin
      e.w = pend[i];
      e.t = t + i * H;
      sb.push_back(e);
    end
    pend.delete();
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    if (!wait_done) return;
    for (k = 0; k < 400 && !req_ready; k++) begin
      if (hold) begin
        req_op   = 3'd4;
        req_data = 8'h55;
        req_char = 8'($urandom);
      end
      @(negedge clk);
    end
    check("ready_time", cyc, t + n * H);
    check("busy_vs_ready", {31'h0, busy}, {31'h0, ~req_ready});
  endtask

  initial begin
    int t;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_x     = 5'd0;
    req_y     = 5'd0;
    req_char  = 8'd0;
    req_attr  = 8'd0;
    req_data  = 8'd0;

    // Reset held for three cycles, then idle and stable.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd", {16'h0, osd_command}, 32'h0000);
    check("rst_ready", {31'h0, req_ready}, 32'd1);
    check("rst_busy", {31'h0, busy}, 32'd0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_cmd", {16'h0, osd_command}, 32'h0000);
      check("idle_ready", {31'h0, req_ready}, 32'd1);
    end
    prev_cmd = 16'h0000;
    mon_en   = 1'b1;

    // PUT_CHAR x=3 y=5 'A' attr 0x70.
    expect_w(16'h1003); expect_w(16'h1105); expect_w(16'h1241); expect_w(16'h1370);
    issue(3'd2, 5'd3, 5'd5, 8'h41, 8'h70, 8'h00, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("last_word_kept", {16'h0, osd_command}, 32'h1370);

    // Repeated FONT_BYTE needs a spacer.
    expect_w(16'h21AA);
    issue(3'd4, 5'd0, 5'd0, 8'h00, 8'h00, 8'hAA, 1'b0, 1'b1);
    expect_w(16'h0000); expect_w(16'h21AA);
    issue(3'd4, 5'd0, 5'd0, 8'h00, 8'h00, 8'hAA, 1'b0, 1'b1);

    // Repeated FONT_RESET needs a spacer.
    expect_w(16'h2001);
    issue(3'd3, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    expect_w(16'h0000); expect_w(16'h2001);
    issue(3'd3, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);

    // Overlay/popup enables: distinct words, no spacers.
    expect_w(16'h0101);
    issue(3'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b1);
    expect_w(16'h0201);
    issue(3'd1, 5'd0, 5'd0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1);
    expect_w(16'h0100);
    issue(3'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'hFE, 1'b0, 1'b1);

    // Backpressure: valid held high with changing fields; next request on the ready cycle.
    expect_w(16'h101F); expect_w(16'h1100); expect_w(16'h127E); expect_w(16'h130F);
    issue(3'd2, 5'd31, 5'd0, 8'h7E, 8'h0F, 8'h00, 1'b1, 1'b1);
    expect_w(16'h2155);
    issue(3'd4, 5'd0, 5'd0, 8'h00, 8'h00, 8'h55, 1'b0, 1'b1);

    // Reset in the middle of a PUT_CHAR.
    expect_w(16'h1003); expect_w(16'h1105);
    t = cyc + 1;
    begin
      exp_t e;
      issue(3'd2, 5'd3, 5'd5, 8'h41, 8'h70, 8'h00, 1'b0, 1'b0);
      e.w = 16'h0000;
      e.t = t + 6;
      sb.push_back(e);
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_cmd", {16'h0, osd_command}, 32'h0000);
    check("midrst_ready", {31'h0, req_ready}, 32'd1);

    // Op 7: accepted, nothing emitted.
    issue(3'd7, 5'd1, 5'd2, 8'h33, 8'h44, 8'h55, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("op7_cmd", {16'h0, osd_command}, 32'h0000);
      check("op7_ready", {31'h0, req_ready}, 32'd1);
    end

    repeat (H + 2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case something upstream wedges the stimulus.
  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/osd_cmd_tx.md
Name: osd_cmd_tx

Overview:
- Transmitter end of the 16-bit OSD command bus: converts high-level OSD requests into the word stream consumed by the OSD overlay.
- Word format: command in [15:8], argument in [7:0].
- The overlay acts only when the bus value changes. This block paces the words and inserts NOP spacers so that every intended word is seen as a change.
- Sits between the control/boot logic and the overlay's osd_command input, in the same clock domain.

Parameters:
- HOLD_CYCLES, 4: clock cycles each emitted word, including spacers, is held on osd_command. Legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle and accepting a request
- req_op  in  3  0=SET_OVERLAY, 1=SET_POPUP, 2=PUT_CHAR, 3=FONT_RESET, 4=FONT_BYTE, 5..7 ignored
- req_x  in  5  column 0..31 (PUT_CHAR)
- req_y  in  5  row 0..31 (PUT_CHAR)
- req_char  in  8  character code (PUT_CHAR)
- req_attr  in  8  attribute byte (PUT_CHAR)
- req_data  in  8  bit0 = enable for SET_OVERLAY/SET_POPUP; font byte for FONT_BYTE
- osd_command  out  16  command word to the overlay
- busy  out  1  = ~req_ready

Behaviour:
- Reset: osd_command=16'h0000, req_ready=1 (from the first cycle after reset deasserts), busy=0, state IDLE, word index=0, hold counter=0.
- Reset asserted mid-sequence: the sequence is abandoned and the next cycle shows 16'h0000.
- Handshake:
  - A request is accepted on a posedge where req_valid & req_ready.
  - All req_* fields are captured into internal registers at acceptance; later changes to req_* are ignored.
  - req_ready=0 from the cycle after acceptance until the sequence completes.
  - req_valid while not ready is held off with no side effects.
- Word lists (n = word count):
  - SET_OVERLAY (n=1): {8'd1, 7'b0, data[0]}
  - SET_POPUP (n=1): {8'd2, 7'b0, data[0]}
  - PUT_CHAR (n=4): {8'd16, 3'b0, x}, {8'd17, 3'b0, y}, {8'd18, char}, {8'd19, attr}
  - FONT_RESET (n=1): 16'h2001
  - FONT_BYTE (n=1): {8'd33, data}
  - ops 5..7: accepted, no words emitted, req_ready stays 1, osd_command unchanged.
- FSM states: IDLE, LOAD, HOLD.
  - IDLE: on accept of a valid op, go to LOAD with word index=0.
  - LOAD: compute next word W.
    - If W == current osd_command, drive 16'h0000 (spacer), set the spacer flag and go to HOLD; the same W is reloaded after the spacer.
    - Otherwise drive W, clear the spacer flag and go to HOLD.
  - HOLD: count HOLD_CYCLES cycles, counted from the cycle the word first appears.
    - When the count expires after a spacer: go back to LOAD with the same index.
    - When it expires after a real word: if index < n-1, increment index and go to LOAD; else go to IDLE.
  - LOAD is merged combinationally into the transition so that no extra cycle is spent per word.
- Timing:
  - Request accepted at edge T: word0 is visible from T+1 through T+HOLD_CYCLES.
  - Word k is visible from T+1+k·HOLD_CYCLES.
  - req_ready=1 at cycle T+1+n·HOLD_CYCLES, plus HOLD_CYCLES for each inserted spacer.
- osd_command keeps the last emitted word while IDLE. It never returns to 0 except through a spacer or reset.
- Because every real word has a nonzero upper byte, a spacer is never equal to a real word. The first word after reset never needs a spacer.
- Widths: x and y are zero-extended to 8 bits. The hold counter is 8 bits and saturates at HOLD_CYCLES-1. The word index is 2 bits.

Test Plan:
- Reset: assert reset for 3 cycles -> osd_command=0x0000, req_ready=1, busy=0; after release with no request, values are stable.
- PUT_CHAR, x=3, y=5, char=0x41, attr=0x70, HOLD_CYCLES=4, accepted at T -> 0x1003 during T+1..T+4, 0x1105 during T+5..T+8, 0x1241 during T+9..T+12, 0x1370 during T+13..T+16; req_ready=1 at T+17; osd_command stays 0x1370.
- Back-to-back FONT_BYTE 0xAA, FONT_BYTE 0xAA (HOLD_CYCLES=4) -> 0x21AA for 4 cycles, then 0x0000 for 4 cycles, then 0x21AA for 4 cycles; the second ready is delayed by the spacer. Two FONT_RESET requests in sequence -> 0x2001, 0x0000, 0x2001.
- SET_OVERLAY en=1, then SET_POPUP en=1, then SET_OVERLAY en=0 -> 0x0101, 0x0201, 0x0100 with no spacers.
- Backpressure: hold req_valid=1 while changing req_char during a PUT_CHAR -> only the captured values appear; req_ready=0 throughout; the next request is accepted only on the ready cycle.
- Reset at T+6 during PUT_CHAR -> osd_command=0x0000 at T+7, req_ready=1. Op 7 accepted -> no change on osd_command, req_ready stays 1.
